// File: rtl/uart_boot_loader_if.sv
// Memory write port driven by the UART boot loader while it owns Memory.
interface uart_boot_loader_if;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_write;

    modport master (output mem_addr, output mem_data, output mem_write);
    modport slave  (input  mem_addr, input  mem_data, input  mem_write);
endinterface

// File: rtl/uart_boot_loader.sv
// Receives a framed program image over 8N1 UART and writes it into Memory from address 0.
// Frame: 0xA5, LEN_LO, LEN_HI, LEN payload bytes, 8-bit additive checksum of the payload.
module uart_boot_loader #(
    parameter int unsigned CLK_FREQ = 27_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    uart_boot_loader_if.master    mem,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned ADDR_W       = 16;
    localparam int unsigned DATA_W       = 8;
    localparam logic [DATA_W-1:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

    // rx synchroniser; rx_prev gives the falling-edge reference
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    rx_state_t          rx_state_q, rx_state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               byte_valid_c;
    logic               frame_err_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state_q <= R_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

    // Bit timing: start re-checked at half a bit, data/stop sampled one bit apart from there
    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_c = 1'b0;
        frame_err_c  = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_d = R_START;
                    cnt_d      = '0;
                end
            end
            R_START: begin
                if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = rx_sync ? R_IDLE : R_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            R_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[DATA_W-1:1]};
                    if (bit_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            R_STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d        = '0;
                    rx_state_d   = R_IDLE;
                    byte_valid_c = rx_sync;
                    frame_err_c  = !rx_sync;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  sum_q, sum_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_data_q, mem_data_d;
    logic               mem_write_q, mem_write_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [ADDR_W-1:0]  len_full_c;

    assign len_full_c = {shift_q, len_q[7:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_SYNC;
            len_q       <= '0;
            addr_q      <= '0;
            sum_q       <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            sum_q       <= sum_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_write_q <= mem_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Frame parser; status flags are decoded from the next state so they line up with the write strobe
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        sum_d       = sum_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_write_d = 1'b0;
        if (frame_err_c && state_q != S_DONE) begin
            state_d = S_ERR;
        end else if (byte_valid_c) begin
            case (state_q)
                S_SYNC, S_ERR: begin
                    if (shift_q == SYNC_BYTE) begin
                        state_d = S_LEN_LO;
                        addr_d  = '0;
                        sum_d   = '0;
                    end
                end
                S_LEN_LO: begin
                    len_d   = {len_q[15:8], shift_q};
                    state_d = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_d = len_full_c;
                    if (len_full_c > ADDR_W'(MEM_SIZE)) begin
                        state_d = S_ERR;
                    end else if (len_full_c == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_data_d  = shift_q;
                    addr_d      = addr_q + ADDR_W'(1);
                    sum_d       = sum_q + shift_q;
                    if (addr_q + ADDR_W'(1) == len_q) begin
                        state_d = S_CSUM;
                    end
                end
                S_CSUM: state_d = (shift_q == sum_q) ? S_DONE : S_ERR;
                default: state_d = state_q;
            endcase
        end
        busy_d  = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                  (state_d == S_DATA)   || (state_d == S_CSUM);
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
    end

    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_data  = mem_data_q;
    assign mem.mem_write = mem_write_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
endmodule
